mem_copy_engine: RTL and testbench
==================================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: data_width, 16, memory word width in bits.
REQ-002 Parameter: addr_width, 9, memory bus address width in bits.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low (asserted at 0); forces reset state immediately, independent of clk.
REQ-005 Port: start  input  1  request a copy; sampled only in IDLE.
REQ-006 Port: src_addr  input  addr_width  first source word address; latched on accepted start.
REQ-007 Port: dst_addr  input  addr_width  first destination word address; latched on accepted start.
REQ-008 Port: len  input  addr_width  word count, 0..511; latched on accepted start.
REQ-009 Port: read_data  input  data_width  shared memory bus read data; valid one cycle after MREAD is first presented.
REQ-010 Port: mem_cmd  output  2  bus command: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10; 2'b11 never driven.
REQ-011 Port: mem_addr  output  addr_width  bus address.
REQ-012 Port: write_data  output  data_width  bus write data.
REQ-013 Port: busy  output  1  high in RD, RDW, WR.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: count  output  addr_width  words written so far in the current or last transfer.

Function
REQ-016 The block SHALL act as the bus initiator toward the existing synchronous RAM and memory-mapped responders, with one-cycle registered read latency.
REQ-017 The block SHALL implement exactly five states: IDLE, RD, RDW, WR, DONE.
REQ-018 Outputs mem_cmd, mem_addr, write_data, busy, and done SHALL be functions of state and internal registers only (Moore), never of start or read_data.
REQ-019 IDLE: mem_cmd=MNONE, mem_addr=0, write_data=0; start=1 latches src/dst/len and clears count; goes to RD if len!=0, else DONE.
REQ-020 RD: mem_cmd=MREAD, mem_addr=current source pointer; next state RDW.
REQ-021 RDW: mem_cmd=MREAD, same mem_addr as RD; read_data captured into the data register at the end of the cycle; next state WR.
REQ-022 WR: mem_cmd=MWRITE, mem_addr=current destination pointer, write_data=data register; at the end of the cycle both pointers increment by 1 and count increments by 1.
REQ-023 WR exit: goes to DONE when the incremented count equals latched len, else RD.
REQ-024 DONE: done=1, mem_cmd=MNONE for exactly one cycle; next state IDLE unconditionally.
REQ-025 Each word SHALL take exactly 3 cycles, for 3*len busy cycles per transfer; no idle cycle between words.
REQ-026 Pointers SHALL wrap modulo 2**addr_width (0x1FF+1=0x000); no error on wrap.
REQ-027 start SHALL be ignored in RD, RDW, WR, and DONE; the latched parameters SHALL NOT change mid-transfer.
REQ-028 Overlapping src/dst ranges SHALL be copied strictly in ascending address order with no hazard correction.
REQ-029 count SHALL hold its final value after DONE until the next accepted start or reset.

Reset
REQ-030 While reset=0: state=IDLE, mem_cmd=MNONE, mem_addr=0, write_data=0, busy=0, done=0, count=0, and pointers, length, and data registers cleared.
REQ-031 Reset asserted mid-transfer SHALL drop mem_cmd to MNONE combinationally in the same cycle; a pending write SHALL NOT occur.
REQ-032 After reset deassertion, the first start SHALL be accepted on the next rising clk edge.

Verification
REQ-033 Reset: drive reset=0 asynchronously between edges -> mem_cmd=00, busy=0, done=0, count=0 immediately.
REQ-034 Single word: RAM[0x010]=0xABCD, start with src=0x010, dst=0x020, len=1 -> RD/RDW at 0x010, WR at 0x020 with 0xABCD, done on the 4th cycle after start, count=1, RAM[0x020]=0xABCD.
REQ-035 Zero length: start with len=0 -> no MREAD or MWRITE ever, busy never high, done pulses the cycle after start, count=0.
REQ-036 Wrap: src=0x1FE, dst=0x0F0, len=4 -> reads 0x1FE, 0x1FF, 0x000, 0x001 -> writes 0x0F0..0x0F3; 12 busy cycles.
REQ-037 Start while busy: second start with different parameters during WR of word 1 of a len=3 transfer -> ignored, original transfer completes with count=3.
REQ-038 Reset mid-operation: reset=0 during RDW of word 2 -> mem_cmd=00 that cycle, destination word 2 unchanged, and a subsequent start runs the full copy normally.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine acting as bus initiator on a synchronous RAM bus.
// Each word is moved in three cycles: issue read, wait for registered read data, then write it.
module mem_copy_engine #(
  parameter int data_width = 16,
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [addr_width-1:0] len,
  input  logic [data_width-1:0] read_data,
  output logic [1:0]            mem_cmd,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] write_data,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  localparam logic [addr_width-1:0] addr_one = {{(addr_width-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [addr_width-1:0] src_ptr_r;
  logic [addr_width-1:0] dst_ptr_r;
  logic [addr_width-1:0] len_r;

  // Control FSM; bus outputs are registered with the value belonging to the next state,
  // and write_data doubles as the data register (captured at the end of RDW).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      src_ptr_r  <= '0;
      dst_ptr_r  <= '0;
      len_r      <= '0;
      count      <= '0;
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          write_data <= '0;
          if (start) begin
            src_ptr_r <= src_addr;
            dst_ptr_r <= dst_addr;
            len_r     <= len;
            count     <= '0;
            if (len != '0) begin
              state_r  <= RD;
              mem_cmd  <= MREAD;
              mem_addr <= src_addr;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else begin
              state_r  <= DONE;
              mem_cmd  <= MNONE;
              mem_addr <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end else begin
            state_r  <= IDLE;
            mem_cmd  <= MNONE;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end
        end

        RD: begin
          state_r  <= RDW;
          mem_cmd  <= MREAD;
          mem_addr <= src_ptr_r;
          busy     <= 1'b1;
          done     <= 1'b0;
        end

        RDW: begin
          state_r    <= WR;
          write_data <= read_data;
          mem_cmd    <= MWRITE;
          mem_addr   <= dst_ptr_r;
          busy       <= 1'b1;
          done       <= 1'b0;
        end

        WR: begin
          // Pointers wrap naturally at the address width.
          src_ptr_r  <= src_ptr_r + addr_one;
          dst_ptr_r  <= dst_ptr_r + addr_one;
          count      <= count + addr_one;
          write_data <= '0;
          if ((count + addr_one) == len_r) begin
            state_r  <= DONE;
            mem_cmd  <= MNONE;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            state_r  <= RD;
            mem_cmd  <= MREAD;
            mem_addr <= src_ptr_r + addr_one;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        DONE: begin
          state_r    <= IDLE;
          mem_cmd    <= MNONE;
          mem_addr   <= '0;
          write_data <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end

        default: begin
          state_r    <= IDLE;
          mem_cmd    <= MNONE;
          mem_addr   <= '0;
          write_data <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a synchronous RAM on the bus plus an
// array-based reference of what memory and the bus should look like per copy.
module tb_mem_copy_engine;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW-1:0] len = '0;
  logic [DW-1:0] read_data = '0;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] count;

  logic [DW-1:0] ram   [DEPTH];
  logic [DW-1:0] model [DEPTH];
  logic          load = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_copy_engine #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .read_data(read_data), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle registered read; bulk load from the model on request.
  always @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < DEPTH; j++) ram[j] <= model[j];
    end else begin
      if (mem_cmd == 2'b01) read_data <= ram[mem_addr];
      if (mem_cmd == 2'b10) ram[mem_addr] <= write_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus observation: address only meaningful with a command, data only with a write.
  function automatic logic [63:0] view(input logic [1:0] c, input logic [AW-1:0] a,
                                       input logic [DW-1:0] w, input logic b, input logic d);
    logic [AW-1:0] am;
    logic [DW-1:0] wm;
    am = (c != 2'b00) ? a : '0;
    wm = (c == 2'b10) ? w : '0;
    return 64'({c, am, wm, b, d});
  endfunction

  task automatic check_ram(input string tag);
    int bad = 0;
    for (int j = 0; j < DEPTH; j++) if (ram[j] !== model[j]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  // Caller is at a negedge. Runs one copy, checking the bus every cycle against the
  // reference; 'inj' names a cycle after which a stray start is driven.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [AW-1:0] n, input int inj);
    int            nw;
    int            busy_cycles;
    logic [AW-1:0] sa;
    logic [AW-1:0] da;
    logic [DW-1:0] w;
    logic [63:0]   exp;
    nw = int'(n);
    busy_cycles = 0;
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    start = 1'b0; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = AW'($urandom);
    for (int k = 1; k <= 3 * nw + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 3 * nw) begin
        sa = s + AW'((k - 1) / 3);
        da = d + AW'((k - 1) / 3);
        if ((k - 1) % 3 == 2) begin
          w = model[sa];
          exp = view(2'b10, da, w, 1'b1, 1'b0);
          model[da] = w;
        end else begin
          exp = view(2'b01, sa, '0, 1'b1, 1'b0);
        end
      end else begin
        exp = view(2'b00, '0, '0, 1'b0, 1'b1);
      end
      check($sformatf("bus_s%0h_d%0h_n%0d_cyc%0d", s, d, nw, k),
            view(mem_cmd, mem_addr, write_data, busy, done), exp);
      if (busy) busy_cycles++;
      if (k == inj) begin
        start = 1'b1; src_addr = s + 9'h0AA; dst_addr = d + 9'h055; len = 9'd7;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", view(mem_cmd, mem_addr, write_data, busy, done), 64'd0);
    check("idle_addr_wdata", 64'({mem_addr, write_data}), 64'd0);
    check("busy_cycles", 64'(busy_cycles), 64'(3 * nw));
    check("final_count", 64'(count), 64'(n));
    check_ram("ram_after_copy");
  endtask

  initial begin
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    logic [DW-1:0] keep;

    for (int j = 0; j < DEPTH; j++) model[j] = DW'($urandom);
    model[9'h010] = 16'hABCD;
    load = 1'b1;

    // Reset asserted from time zero: outputs must already be quiet.
    #3;
    check("reset_outputs", view(mem_cmd, mem_addr, write_data, busy, done), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_ram("ram_preload");

    // Single word, first start right after reset release.
    run_copy(9'h010, 9'h020, 9'd1, 0);
    check("single_word_data", 64'(ram[9'h020]), 64'h0000_0000_0000_ABCD);

    // Zero length: only a done pulse.
    @(negedge clk);
    run_copy(9'h033, 9'h044, 9'd0, 0);

    // Address wrap on the source side.
    @(negedge clk);
    run_copy(9'h1FE, 9'h0F0, 9'd4, 0);

    // Stray start during WR of the first word must be ignored.
    @(negedge clk);
    run_copy(9'h030, 9'h060, 9'd3, 3);

    // Overlapping ranges, destination above source: ascending order replicates.
    @(negedge clk);
    run_copy(9'h050, 9'h052, 9'd6, 0);

    // Randomised copies.
    for (int t = 0; t < 4; t++) begin
      rs = AW'($urandom);
      rd = AW'($urandom);
      @(negedge clk);
      run_copy(rs, rd, AW'($urandom_range(1, 20)), 0);
    end

    // Reset during RDW of word 2 of a 3-word copy.
    @(negedge clk);
    keep = model[9'h141];
    start = 1'b1; src_addr = 9'h100; dst_addr = 9'h140; len = 9'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_rdw", 64'({mem_cmd, mem_addr}), 64'({2'b01, 9'h101}));
    #2 reset = 1'b0;
    #1;
    check("midreset_outputs", view(mem_cmd, mem_addr, write_data, busy, done), 64'd0);
    check("midreset_count", 64'(count), 64'd0);
    model[9'h140] = model[9'h100];
    @(negedge clk);
    check("word2_untouched", 64'(ram[9'h141]), 64'(keep));
    check_ram("ram_after_reset");
    reset = 1'b1;
    run_copy(9'h100, 9'h140, 9'd3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
